// File: rtl/fc_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fc_rd_ctrl
//  Brief    : Read-side bus master for the fully-connected layer. Fetches
//             BATCH_SIZE*IN_SIZE words in single-outstanding bursts of up to
//             16 beats and presents them packed with a one-cycle enable.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_rd_ctrl #(
  parameter int         BATCH_SIZE = 1,
  parameter int         IN_SIZE    = 32,
  parameter logic [3:0] ARID       = 4'b0101
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [27:0]                      NcNrc_initAddr,
  input  logic                             NcNrc_initAddrEn,
  input  logic                             NcNrc_start,
  output logic                             NrcNc_done,
  output logic                             NrcNc_err,
  input  logic                             BusNrc_arready,
  output logic                             NrcBus_arvalid,
  output logic [27:0]                      NrcBus_araddr,
  output logic [3:0]                       NrcBus_arlen,
  output logic [3:0]                       NrcBus_aruser_id,
  output logic                             NrcBus_aruser_ap,
  input  logic                             BusNrc_rvalid,
  input  logic [31:0]                      BusNrc_rdata,
  input  logic [3:0]                       BusNrc_ruser_id,
  input  logic                             BusNrc_ruser_last,
  output logic                             NrcBus_rready,
  output logic                             NrcFc_data_en,
  output logic [BATCH_SIZE*IN_SIZE*32-1:0] NrcFc_data
);

  localparam int         TOTAL      = BATCH_SIZE * IN_SIZE;
  localparam int         NBURST     = (TOTAL + 15) / 16;
  localparam int         BCW        = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int         WCW        = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [3:0] LAST_LEN   = 4'((TOTAL - 1) % 16);
  localparam logic [3:0] FULL_LEN   = 4'd15;
  localparam logic [BCW-1:0] LAST_BURST = BCW'(NBURST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [27:0]      base;
  logic [BCW-1:0]   burst_cnt;
  logic [BCW-1:0]   burst_inc;
  logic [3:0]       beat_cnt;
  logic [WCW-1:0]   word_cnt;
  logic             start_ok;
  logic             accept;
  logic             burst_end;

  // Next-state decode plus the per-cycle strobes that drive the datapath
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    burst_end = 1'b0;
    burst_inc = burst_cnt + BCW'(1);
    case (state)
      S_IDLE: begin
        if (NcNrc_start) begin
          start_ok  = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (NrcBus_arvalid && BusNrc_arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        // beats carrying a foreign ID are consumed but otherwise ignored
        accept    = BusNrc_rvalid && (BusNrc_ruser_id == ARID);
        burst_end = accept && (beat_cnt == NrcBus_arlen);
        if (burst_end) state_nxt = (burst_cnt == LAST_BURST) ? S_DONE : S_ADDR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Base address register, loadable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                base <= 28'd0;
    else if (NcNrc_initAddrEn) base <= NcNrc_initAddr;
  end

  // Handshake and status outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NrcBus_arvalid   <= 1'b0;
      NrcBus_rready    <= 1'b0;
      NrcNc_done       <= 1'b0;
      NrcFc_data_en    <= 1'b0;
      NrcBus_aruser_id <= 4'd0;
      NrcBus_aruser_ap <= 1'b0;
    end else begin
      NrcBus_arvalid   <= (state_nxt == S_ADDR);
      NrcBus_rready    <= (state_nxt == S_DATA);
      NrcNc_done       <= (state_nxt == S_DONE);
      NrcFc_data_en    <= (state_nxt == S_DONE);
      NrcBus_aruser_id <= (state_nxt == S_ADDR) ? ARID : 4'd0;
      NrcBus_aruser_ap <= (state_nxt == S_ADDR);
    end
  end

  // Burst address/length and the burst, beat and word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NrcBus_araddr <= 28'd0;
      NrcBus_arlen  <= 4'd0;
      burst_cnt     <= '0;
      beat_cnt      <= 4'd0;
      word_cnt      <= '0;
    end else if (start_ok) begin
      NrcBus_araddr <= base;
      NrcBus_arlen  <= (NBURST == 1) ? LAST_LEN : FULL_LEN;
      burst_cnt     <= '0;
      beat_cnt      <= 4'd0;
      word_cnt      <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + WCW'(1);
      if (burst_end) begin
        // next burst is 64 bytes further on; address wraps at 2^28
        beat_cnt      <= 4'd0;
        burst_cnt     <= burst_inc;
        NrcBus_araddr <= NrcBus_araddr + 28'd64;
        NrcBus_arlen  <= (burst_inc == LAST_BURST) ? LAST_LEN : FULL_LEN;
      end else begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  // Sticky error: ruser_last disagreed with the beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        NrcNc_err <= 1'b0;
    else if (start_ok) NrcNc_err <= 1'b0;
    else if (accept && (BusNrc_ruser_last != (beat_cnt == NrcBus_arlen)))
      NrcNc_err <= 1'b1;
  end

  // Pack accepted beats into the flat result; words persist until overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NrcFc_data <= '0;
    end else begin
      for (int k = 0; k < TOTAL; k++) begin
        if (accept && (word_cnt == WCW'(k))) NrcFc_data[k*32 +: 32] <= BusNrc_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_rd_ctrl
//  Brief    : Self-checking bench for fc_rd_ctrl. Two instances (32 and 20
//             words per fetch) share a bus responder selected by sel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_rd_ctrl;

  localparam logic [3:0] ARID = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [27:0] init_addr;
  logic        init_en, start, arready, rvalid, rlast;
  logic [31:0] rdata;
  logic [3:0]  rid;

  logic         done0, err0, arvalid0, ap0, rready0, den0;
  logic [27:0]  araddr0;
  logic [3:0]   arlen0, aid0;
  logic [1023:0] data0;
  logic         done1, err1, arvalid1, ap1, rready1, den1;
  logic [27:0]  araddr1;
  logic [3:0]   arlen1, aid1;
  logic [639:0] data1;

  wire start0 = start & ~sel, start1 = start & sel;
  wire arr0 = arready & ~sel, arr1 = arready & sel;
  wire rv0 = rvalid & ~sel, rv1 = rvalid & sel;

  wire           done_m    = sel ? done1    : done0;
  wire           err_m     = sel ? err1     : err0;
  wire           arvalid_m = sel ? arvalid1 : arvalid0;
  wire           ap_m      = sel ? ap1      : ap0;
  wire           rready_m  = sel ? rready1  : rready0;
  wire           den_m     = sel ? den1     : den0;
  wire [27:0]    araddr_m  = sel ? araddr1  : araddr0;
  wire [3:0]     arlen_m   = sel ? arlen1   : arlen0;
  wire [3:0]     aid_m     = sel ? aid1     : aid0;
  wire [1023:0]  data_m    = sel ? {384'd0, data1} : data0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_rd_ctrl #(.BATCH_SIZE(1), .IN_SIZE(32), .ARID(ARID)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .NcNrc_initAddr(init_addr), .NcNrc_initAddrEn(init_en),
    .NcNrc_start(start0), .NrcNc_done(done0), .NrcNc_err(err0),
    .BusNrc_arready(arr0), .NrcBus_arvalid(arvalid0), .NrcBus_araddr(araddr0),
    .NrcBus_arlen(arlen0), .NrcBus_aruser_id(aid0), .NrcBus_aruser_ap(ap0),
    .BusNrc_rvalid(rv0), .BusNrc_rdata(rdata), .BusNrc_ruser_id(rid),
    .BusNrc_ruser_last(rlast), .NrcBus_rready(rready0), .NrcFc_data_en(den0),
    .NrcFc_data(data0));

  fc_rd_ctrl #(.BATCH_SIZE(1), .IN_SIZE(20), .ARID(ARID)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .NcNrc_initAddr(init_addr), .NcNrc_initAddrEn(init_en),
    .NcNrc_start(start1), .NrcNc_done(done1), .NrcNc_err(err1),
    .BusNrc_arready(arr1), .NrcBus_arvalid(arvalid1), .NrcBus_araddr(araddr1),
    .NrcBus_arlen(arlen1), .NrcBus_aruser_id(aid1), .NrcBus_aruser_ap(ap1),
    .BusNrc_rvalid(rv1), .BusNrc_rdata(rdata), .BusNrc_ruser_id(rid),
    .BusNrc_ruser_last(rlast), .NrcBus_rready(rready1), .NrcFc_data_en(den1),
    .NrcFc_data(data1));

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset mid-fetch, then R beats offered while idle
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_arvalid", arvalid_m, 0);
    check("rst_rready",  rready_m,  0);
    check("rst_done",    done_m,    0);
    check("rst_den",     den_m,     0);
    check("rst_err",     err_m,     0);
    check("rst_araddr",  araddr_m,  0);
    check("rst_arlen",   arlen_m,   0);
    check("rst_aid",     aid_m,     0);
    check("rst_ap",      ap_m,      0);
    check("rst_data",    data_m,    0);
    rvalid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      rvalid = 1'b1; rid = ARID; rdata = $urandom; rlast = 1'b0;
      @(negedge clk);
      check("idle_rready", rready_m, 0);
      check("idle_data",   data_m,   0);
    end
    rvalid = 1'b0;
  endtask

  // One fetch. Expected bursts and result come from the burst-split rule:
  // burst b starts at base+64b and carries min(16, TOTAL-16b) words.
  // Negative *_at arguments disable the corresponding disturbance.
  task automatic do_fetch(input bit s, input logic [27:0] base, input bit rnd,
                          input int stall, input int gmax, input int bad_at,
                          input int wrong_at, input int start_at, input int rst_at);
    int total, nb, len, g;
    logic [1023:0] exp_data;
    logic exp_err;
    logic [27:0] ea;
    logic [31:0] w;
    total = s ? 20 : 32;
    nb = (total + 15) / 16;
    exp_data = '0; exp_err = 1'b0; g = 0;
    @(negedge clk) sel = s; init_addr = base; init_en = 1'b1;
    @(negedge clk) init_en = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("err_clear", err_m, 0);
    for (int b = 0; b < nb; b++) begin
      len = (total - 16*b >= 16) ? 15 : total - 16*b - 1;
      ea  = base + 28'(64*b);
      check("arvalid", arvalid_m, 1);
      check("araddr",  araddr_m,  ea);
      check("arlen",   arlen_m,   len);
      check("aruser_id", aid_m,   ARID);
      check("aruser_ap", ap_m,    1);
      check("rready_addr", rready_m, 0);
      repeat (stall) begin
        @(negedge clk);
        check("stall_araddr", araddr_m, ea);
        check("stall_arlen",  arlen_m,  len);
        check("stall_arvalid", arvalid_m, 1);
      end
      arready = 1'b1;
      @(negedge clk) arready = 1'b0;
      check("arvalid_off", arvalid_m, 0);
      check("rready_on",   rready_m,  1);
      for (int j = 0; j <= len; j++) begin
        if (g == rst_at) begin
          do_reset();
          return;
        end
        if (g == start_at) begin
          start = 1'b1;
          @(negedge clk) start = 1'b0;
          check("start_ignored", arvalid_m, 0);
          check("start_rready",  rready_m,  1);
        end
        repeat ($urandom_range(0, gmax)) @(negedge clk);
        if (g == bad_at) begin
          rvalid = 1'b1; rid = 4'b0110; rdata = 32'hDEAD_BEEF; rlast = 1'b0;
          @(negedge clk);
        end
        w = rnd ? $urandom : 32'hA000_0000 + 32'(g);
        rvalid = 1'b1; rid = ARID; rdata = w;
        rlast = (j == len) ^ (g == wrong_at);
        if (rlast != (j == len)) exp_err = 1'b1;
        exp_data[32*g +: 32] = w;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        g++;
        if (j == len && b < nb - 1) check("no_early_done", done_m, 0);
      end
    end
    check("done",    done_m,   1);
    check("data_en", den_m,    1);
    check("data",    data_m,   exp_data);
    check("err",     err_m,    exp_err);
    check("done_arvalid", arvalid_m, 0);
    check("done_rready",  rready_m,  0);
    @(negedge clk);
    check("done_pulse", done_m, 0);
    check("den_pulse",  den_m,  0);
    repeat (2) @(negedge clk);
    check("data_hold",  data_m, exp_data);
    check("err_sticky", err_m,  exp_err);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; init_addr = '0; init_en = 1'b0; start = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;
    repeat (3) @(negedge clk);
    check("reset_arvalid", arvalid_m, 0);
    check("reset_rready",  rready_m,  0);
    check("reset_done",    done_m,    0);
    check("reset_data",    data_m,    0);
    rst_n = 1'b1;
    // baseline 32 words, fixed pattern
    do_fetch(1'b0, 28'h0001000, 1'b0, 0, 0, -1, -1, -1, -1);
    // 20 words: full burst then a 4-beat burst
    do_fetch(1'b1, 28'h0002000, 1'b1, 0, 0, -1, -1, -1, -1);
    // AR stall and random R gaps
    do_fetch(1'b0, 28'h0003000, 1'b1, 3, 2, -1, -1, -1, -1);
    // foreign-ID beat mid-burst
    do_fetch(1'b0, 28'h0001000, 1'b0, 0, 0, 5, -1, -1, -1);
    // early ruser_last on beat 10 of the first burst
    do_fetch(1'b0, 28'h0004000, 1'b1, 0, 0, -1, 10, -1, -1);
    // stray start during DATA; also clears the previous error
    do_fetch(1'b0, 28'h0005000, 1'b1, 1, 1, -1, -1, 20, -1);
    // address wrap at 2^28
    do_fetch(1'b1, 28'hFFFFFC0, 1'b1, 2, 2, -1, -1, -1, -1);
    // reset mid-burst, then a clean fetch
    do_fetch(1'b0, 28'h0006000, 1'b1, 0, 0, -1, -1, -1, 7);
    do_fetch(1'b0, 28'h0007000, 1'b1, 0, 1, -1, -1, -1, -1);
    // mixed disturbances on the 20-word instance
    do_fetch(1'b1, 28'h0008000, 1'b1, 1, 2, 17, 3, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
